// File: rtl/eth_tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_scheduler
//
// Read-side scheduler between the TX packet FIFO (first-word-fall-through,
// 9-bit entries {data[7:0], tlast}) and the TX MAC AXI-stream input. All logic
// runs in the clk_125 domain.
//
// A frame is started only once at least one complete packet has been committed
// to the FIFO, so the MAC never sees an underrun inside a frame. Frames longer
// than MAX_FRAME_BYTES are cut (tlast+tuser on the last forwarded byte) and the
// rest of the packet is drained from the FIFO. After every frame an idle gap of
// IFG_CYCLES cycles is enforced.
//
// Build option:
//   ETH_TX_SCHED_PAD_EN  defined   : frames shorter than MIN_FRAME_BYTES are
//                                    padded with 8'h00 up to that length.
//                        undefined : frames pass unpadded; MIN_FRAME_BYTES is
//                                    only range-checked.
//
// Ports:
//   clk_125          in   125 MHz clock
//   i_reset_n        in   synchronous active-low reset
//   i_pkt_committed  in   1-cycle pulse: one complete packet written to FIFO
//   i_fifo_data      in   FIFO head, [8:1] data byte, [0] tlast
//   i_fifo_empty     in   FIFO empty
//   o_fifo_rd_en     out  pop FIFO head this cycle
//   m_axis_tdata     out  byte to MAC
//   m_axis_tvalid    out  byte valid
//   m_axis_tlast     out  final byte of frame
//   m_axis_tuser     out  frame error (truncation), valid with tlast
//   s_axis_trdy      in   MAC accepts byte
//   o_pkt_count      out  committed packets not yet fully consumed
//   o_tx_busy        out  scheduler not idle
//   o_trunc_err      out  1-cycle pulse when a frame is truncated
// -----------------------------------------------------------------------------
module eth_tx_frame_scheduler #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int IFG_CYCLES      = 12,
    parameter int PKT_CNT_WIDTH   = 9
) (
    input  logic                     clk_125,
    input  logic                     i_reset_n,
    input  logic                     i_pkt_committed,
    input  logic [8:0]               i_fifo_data,
    input  logic                     i_fifo_empty,
    output logic                     o_fifo_rd_en,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     s_axis_trdy,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_count,
    output logic                     o_tx_busy,
    output logic                     o_trunc_err
);

    localparam int BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [BCNT_W-1:0] MAX_LAST = BCNT_W'(MAX_FRAME_BYTES - 1);
    // IFG_CYCLES=0 still spends one cycle in GAP.
    localparam logic [GAP_W-1:0]  GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

    if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > MAX_FRAME_BYTES) begin : g_param_check
        $error("MIN_FRAME_BYTES must lie in 1..MAX_FRAME_BYTES");
    end

`ifdef ETH_TX_SCHED_PAD_EN
    localparam logic [BCNT_W-1:0] MIN_LAST = BCNT_W'(MIN_FRAME_BYTES - 1);
    typedef enum logic [2:0] {IDLE, SEND, PAD, DISCARD, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, DISCARD, GAP} state_t;
`endif

    state_t              state, state_n;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                beat_ok;

    // Saturating up/down step of the committed-packet counter. A simultaneous
    // commit and tlast pop cancel out.
    function automatic logic [PKT_CNT_WIDTH-1:0] pkt_count_step(
        input logic [PKT_CNT_WIDTH-1:0] cnt,
        input logic                     inc,
        input logic                     dec
    );
        logic [PKT_CNT_WIDTH-1:0] res;
        res = cnt;
        if (inc && !dec && cnt != '1) begin
            res = cnt + PKT_CNT_WIDTH'(1);
        end else if (dec && !inc && cnt != '0) begin
            res = cnt - PKT_CNT_WIDTH'(1);
        end
        return res;
    endfunction

    always_ff @(posedge clk_125) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            o_pkt_count <= '0;
        end else begin
            state <= state_n;
            // Cleared while idle, so it is zero on entry to SEND.
            if (state == IDLE) begin
                byte_cnt <= '0;
            end else if (beat_ok) begin
                byte_cnt <= byte_cnt + BCNT_W'(1);
            end
            if (state == GAP && state_n == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
            o_pkt_count <= pkt_count_step(o_pkt_count, i_pkt_committed,
                                          o_fifo_rd_en && i_fifo_data[0]);
        end
    end

    always_comb begin
        state_n       = state;
        o_fifo_rd_en  = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        o_trunc_err   = 1'b0;
        beat_ok       = 1'b0;

        case (state)
            IDLE: begin
                // Registered count: the start decision lags the commit pulse.
                if (o_pkt_count != '0 && !i_fifo_empty) begin
                    state_n = SEND;
                end
            end

            SEND: begin
                m_axis_tvalid = !i_fifo_empty;
                m_axis_tdata  = i_fifo_data[8:1];
                if (!i_fifo_empty) begin
                    if (i_fifo_data[0]) begin
`ifdef ETH_TX_SCHED_PAD_EN
                        m_axis_tlast = (byte_cnt >= MIN_LAST);
`else
                        m_axis_tlast = 1'b1;
`endif
                    end else if (byte_cnt == MAX_LAST) begin
                        m_axis_tlast = 1'b1;
                        m_axis_tuser = 1'b1;
                    end
                end
                beat_ok      = m_axis_tvalid && s_axis_trdy;
                o_fifo_rd_en = beat_ok;
                if (beat_ok) begin
                    if (i_fifo_data[0]) begin
`ifdef ETH_TX_SCHED_PAD_EN
                        // Short packet: its tlast is consumed here, the frame
                        // end is produced by PAD instead.
                        state_n = m_axis_tlast ? GAP : PAD;
`else
                        state_n = GAP;
`endif
                    end else if (m_axis_tuser) begin
                        o_trunc_err = 1'b1;
                        state_n     = DISCARD;
                    end
                end
            end

`ifdef ETH_TX_SCHED_PAD_EN
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (byte_cnt == MIN_LAST);
                beat_ok       = s_axis_trdy;
                if (beat_ok && m_axis_tlast) begin
                    state_n = GAP;
                end
            end
`endif

            DISCARD: begin
                o_fifo_rd_en = !i_fifo_empty;
                if (!i_fifo_empty && i_fifo_data[0]) begin
                    state_n = GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign o_tx_busy = (state != IDLE);

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_frame_scheduler
//
// Directed bench for eth_tx_frame_scheduler. A FWFT FIFO is modelled with an
// array and two pointers. Each written packet is turned into its expected MAC
// frame (truncate to MAX, optionally pad to MIN) and queued; a negedge monitor
// checks every accepted beat against that queue, plus stall stability, no pop
// while empty and the inter-frame gap. Directed checks pin frame lengths,
// counts and reset behaviour with literal values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_tx_frame_scheduler;

    localparam int MIN_B      = 60;
    localparam int MAX_B      = 1514;
    localparam int IFG        = 12;
    localparam int CW         = 9;
    localparam int FIFO_DEPTH = 4096;
`ifdef ETH_TX_SCHED_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic          clk_125 = 1'b0;
    logic          i_reset_n;
    logic          i_pkt_committed;
    logic [8:0]    i_fifo_data;
    logic          i_fifo_empty;
    logic          o_fifo_rd_en;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          s_axis_trdy;
    logic [CW-1:0] o_pkt_count;
    logic          o_tx_busy;
    logic          o_trunc_err;

    always #4 clk_125 = ~clk_125;

    eth_tx_frame_scheduler #(
        .MIN_FRAME_BYTES(MIN_B),
        .MAX_FRAME_BYTES(MAX_B),
        .IFG_CYCLES     (IFG),
        .PKT_CNT_WIDTH  (CW)
    ) dut (
        .clk_125        (clk_125),
        .i_reset_n      (i_reset_n),
        .i_pkt_committed(i_pkt_committed),
        .i_fifo_data    (i_fifo_data),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .s_axis_trdy    (s_axis_trdy),
        .o_pkt_count    (o_pkt_count),
        .o_tx_busy      (o_tx_busy),
        .o_trunc_err    (o_trunc_err)
    );

    // FWFT FIFO model; shares the DUT reset (reset empties it).
    logic [8:0] fifo_mem [FIFO_DEPTH];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign i_fifo_empty = (rd_ptr == wr_ptr);
    assign i_fifo_data  = fifo_mem[rd_ptr % FIFO_DEPTH];

    always @(posedge clk_125) begin
        if (!i_reset_n)        rd_ptr <= wr_ptr;
        else if (o_fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Expected beats {data, tlast, tuser}.
    logic [9:0] exp_q [$];
    int len_log [$];
    int user_log [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Monitor
    int         cur_beats    = 0;
    int         beat_no      = 0;
    int         pops         = 0;
    int         trunc_pulses = 0;
    int         idle_run     = 0;
    int         gap_seen     = -1;
    bit         gap_watch    = 0;
    bit         prev_stall   = 0;
    logic [9:0] prev_out;

    always @(negedge clk_125) begin
        if (!i_reset_n) begin
            cur_beats  = 0;
            prev_stall = 0;
            gap_watch  = 0;
            idle_run   = 0;
        end else begin
            if (o_fifo_rd_en) begin
                pops++;
                chk("pop_while_empty", int'(i_fifo_empty), 0);
            end
            if (o_trunc_err) trunc_pulses++;
            if (prev_stall)
                chk("stall_hold", int'({m_axis_tvalid, m_axis_tdata, m_axis_tlast}), int'(prev_out));
            if (gap_watch) begin
                if (m_axis_tvalid) begin
                    gap_seen  = idle_run;
                    gap_watch = 0;
                    chk("ifg_min_idle", int'(idle_run >= IFG + 1), 1);
                end else begin
                    idle_run++;
                end
            end
            if (m_axis_tvalid && s_axis_trdy) begin
                beat_no++;
                chk("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d_data_last_user", beat_no),
                        int'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), int'(e));
                end
                cur_beats++;
                if (m_axis_tlast) begin
                    len_log.push_back(cur_beats);
                    user_log.push_back(int'(m_axis_tuser));
                    cur_beats = 0;
                    gap_watch = 1;
                    idle_run  = 0;
                end
            end
            prev_stall = m_axis_tvalid && !s_axis_trdy;
            prev_out   = {m_axis_tvalid, m_axis_tdata, m_axis_tlast};
        end
    end

    bit toggle_rdy = 0;

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    // Write a packet to the FIFO and queue the frame the MAC must receive.
    task automatic write_pkt(input int len, input int seed);
        int n;
        n = (len > MAX_B) ? MAX_B : len;
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            logic       lst;
            logic       usr;
            b = 8'(seed + i * 7);
            fifo_mem[wr_ptr % FIFO_DEPTH] = {b, (i == len - 1)};
            wr_ptr++;
            if (i < n) begin
                lst = (i == n - 1) && (len > MAX_B || !PAD_ON || n >= MIN_B);
                usr = (i == n - 1) && (len > MAX_B);
                exp_q.push_back({b, lst, usr});
            end
        end
        if (PAD_ON && len <= MAX_B)
            for (int i = n; i < MIN_B; i++) exp_q.push_back({8'h00, (i == MIN_B - 1), 1'b0});
    endtask

    task automatic commit();
        i_pkt_committed = 1'b1;
        tick();
        i_pkt_committed = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || o_tx_busy) && c < budget) begin
            tick();
            c++;
            if (toggle_rdy) s_axis_trdy = !s_axis_trdy;
        end
        chk({nm, "_in_budget"}, int'(c < budget), 1);
        chk({nm, "_beats_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, p0, t0, c;
        i_reset_n       = 1'b0;
        i_pkt_committed = 1'b0;
        s_axis_trdy     = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tlast",  int'(m_axis_tlast), 0);
        chk("rst_tuser",  int'(m_axis_tuser), 0);
        chk("rst_tdata",  int'(m_axis_tdata), 0);
        chk("rst_rd_en",  int'(o_fifo_rd_en), 0);
        chk("rst_count",  int'(o_pkt_count), 0);
        chk("rst_busy",   int'(o_tx_busy), 0);
        chk("rst_trunc",  int'(o_trunc_err), 0);
        i_reset_n = 1'b1;
        repeat (2) tick();

        // 64-byte packet
        f0 = len_log.size(); p0 = pops; t0 = trunc_pulses;
        write_pkt(64, 8'h10);
        commit();
        chk("t1_count_after_commit", int'(o_pkt_count), 1);
        wait_done("t1", 2000);
        chk("t1_frames", len_log.size() - f0, 1);
        if (len_log.size() > f0) begin
            chk("t1_len", len_log[f0], 64);
            chk("t1_user", user_log[f0], 0);
        end
        chk("t1_pops", pops - p0, 64);
        chk("t1_trunc", trunc_pulses - t0, 0);
        chk("t1_count_end", int'(o_pkt_count), 0);

        // 20-byte packet (padded or not depending on build)
        f0 = len_log.size(); p0 = pops;
        write_pkt(20, 8'h40);
        commit();
        wait_done("t2", 2000);
        chk("t2_frames", len_log.size() - f0, 1);
        if (len_log.size() > f0) begin
`ifdef ETH_TX_SCHED_PAD_EN
            chk("t2_len", len_log[f0], 60);
`else
            chk("t2_len", len_log[f0], 20);
`endif
        end
        chk("t2_pops", pops - p0, 20);

        // 1600-byte packet followed by a 64-byte packet
        f0 = len_log.size(); p0 = pops; t0 = trunc_pulses;
        write_pkt(1600, 8'h80);
        write_pkt(64, 8'h33);
        commit();
        commit();
        wait_done("t3", 6000);
        chk("t3_frames", len_log.size() - f0, 2);
        if (len_log.size() > f0 + 1) begin
            chk("t3_trunc_len",  len_log[f0], 1514);
            chk("t3_trunc_user", user_log[f0], 1);
            chk("t3_next_len",   len_log[f0 + 1], 64);
            chk("t3_next_user",  user_log[f0 + 1], 0);
        end
        chk("t3_trunc_pulses", trunc_pulses - t0, 1);
        chk("t3_pops", pops - p0, 1664);
        chk("t3_count_end", int'(o_pkt_count), 0);

        // trdy toggling every cycle
        f0 = len_log.size(); p0 = pops;
        write_pkt(64, 8'hC5);
        commit();
        toggle_rdy = 1;
        wait_done("t4", 3000);
        toggle_rdy  = 0;
        s_axis_trdy = 1'b1;
        chk("t4_frames", len_log.size() - f0, 1);
        if (len_log.size() > f0) chk("t4_len", len_log[f0], 64);
        chk("t4_pops", pops - p0, 64);

        // commit pulse coincident with the tlast pop at count=1
        f0 = len_log.size();
        write_pkt(64, 8'h01);
        commit();
        write_pkt(64, 8'h77);
        c = 0;
        while (!(m_axis_tvalid && m_axis_tlast && s_axis_trdy) && c < 500) begin
            tick();
            c++;
        end
        chk("t5_found_last_beat", int'(c < 500), 1);
        i_pkt_committed = 1'b1;
        tick();
        i_pkt_committed = 1'b0;
        chk("t5_count_held", int'(o_pkt_count), 1);
        wait_done("t5", 2000);
        chk("t5_frames", len_log.size() - f0, 2);
        chk("t5_gap_idle_cycles", gap_seen, IFG + 1);
        chk("t5_count_end", int'(o_pkt_count), 0);

        // reset at beat 30 of a 100-byte frame
        write_pkt(100, 8'h55);
        commit();
        c = 0;
        while (cur_beats != 29 && c < 500) begin
            tick();
            c++;
        end
        chk("t6_reached_beat30", int'(c < 500), 1);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        exp_q.delete();
        chk("t6_tvalid", int'(m_axis_tvalid), 0);
        chk("t6_count",  int'(o_pkt_count), 0);
        chk("t6_busy",   int'(o_tx_busy), 0);
        chk("t6_rd_en",  int'(o_fifo_rd_en), 0);
        chk("t6_tlast",  int'(m_axis_tlast), 0);

        // recovery after reset
        f0 = len_log.size();
        repeat (2) tick();
        write_pkt(64, 8'h99);
        commit();
        wait_done("t7", 2000);
        chk("t7_frames", len_log.size() - f0, 1);
        if (len_log.size() > f0) chk("t7_len", len_log[f0], 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
